vga_board_renderer: RTL and testbench
=====================================

// Module: vga_board_renderer
// PURPOSE
//  Pixel source feeding the vga timing/output stage. It maps the pixel coordinate requested by the
//  timing generator to 24-bit RGB, drawn from an internal COLS x ROWS game-board cell store
//  (3-bit colour code per cell). The game logic writes cells through a valid/ready port.
//  Writes are accepted only during vertical blanking, so no frame shows a half-updated board.
// PARAMETERS
//  COLS       10   board width in cells
//  ROWS       20   board height in cells
//  CELL_LOG2  4    cell edge = 2**CELL_LOG2 pixels (16)
//  ORIGIN_X   240  pixel x of board left edge
//  ORIGIN_Y   80   pixel y of board top edge
// PORTS
//  clk           in   1   pixel clock, 25 MHz
//  rst_n         in   1   asynchronous active-low reset
//  i_pix_req     in   1   coordinate valid (timing generator active area, issued 2 cycles early)
//  i_x           in   10  requested pixel x
//  i_y           in   10  requested pixel y
//  i_vblank      in   1   high during vertical blanking
//  i_clr         in   1   one-cycle pulse: clear whole board to code 0
//  i_wr_valid    in   1   cell write request
//  o_wr_ready    out  1   write accepted when valid&&ready at a rising edge
//  i_wr_col      in   4   target column
//  i_wr_row      in   5   target row
//  i_wr_code     in   3   colour code
//  o_pix_valid   out  1   o_r/o_g/o_b valid
//  o_r,o_g,o_b   out  8   pixel colour, one 8-bit output per channel
// BEHAVIOUR
//  - Reset: all cells 0, FSM IDLE, o_pix_valid=0, o_r=o_g=o_b=0, pipeline valids 0.
//  - Pipeline: fixed 2-cycle latency; request at edge N -> o_* and o_pix_valid at edge N+2.
//    S1 registers in_board, col=(x-ORIGIN_X)>>CELL_LOG2, row=(y-ORIGIN_Y)>>CELL_LOG2 and sub-cell offsets.
//    S2 reads the cell and applies the palette. No stalls; one pixel every cycle.
//  - in_board: ORIGIN_X <= x < ORIGIN_X+COLS<<CELL_LOG2, same for y. Compare unsigned at 11 bits; no wrap.
//  - Outside board: 0x202020 (dark gray background). i_pix_req=0 -> o_pix_valid=0, RGB=0.
//  - Palette: 0 000000, 1 00FFFF, 2 FFFF00, 3 800080, 4 00FF00, 5 FF0000, 6 0000FF, 7 FF8000.
//  - FSM IDLE/CLEAR.
//    IDLE: o_wr_ready = i_vblank && !i_clr (combinational).
//    i_clr in IDLE -> CLEAR. CLEAR zeroes one row per cycle, rows 0..ROWS-1, then returns to IDLE
//    (ROWS cycles total). o_wr_ready=0 throughout CLEAR.
//  - i_clr during CLEAR is ignored; the clear is not restarted.
//  - i_clr and i_wr_valid in the same cycle: clear wins; the write is not accepted (ready low).
//  - An accepted write updates the cell at that edge. It is visible to reads issued from the next cycle on.
//  - A write with col>=COLS or row>=ROWS is accepted (handshake completes) but changes nothing.
//  - i_vblank falling while i_wr_valid is held: ready drops; the write waits for the next blanking.
//  - Pixel reads during CLEAR return the mix of cleared and old rows. Software clears only in blanking.
//  - rst_n asserted mid-clear or mid-frame: immediate return to reset state, pipeline flushed.
// CONFIGURATION
//  GRID_LINE_EN defined: an empty (code 0) in-board pixel whose x or y sub-cell offset is 0 outputs
//    0x404040 grid gray. Filled cells and out-of-board pixels are unchanged.
//  GRID_LINE_EN undefined: empty cells are solid 0x000000; sub-cell offsets need not be pipelined.
// TESTING
//  1 reset, request (250,90) -> 2 cycles later o_pix_valid=1, RGB=000000 (GRID_LINE_EN: 404040 at (240,80)).
//  2 vblank=1, write col0 row0 code5, then request (241,81) -> FF0000 on cycle N+2.
//  3 vblank=0, wr_valid=1 -> o_wr_ready=0, cell unchanged. Raise vblank -> accepted that cycle.
//  4 fill cells, pulse i_clr with wr_valid -> ready=0 for 20 cycles, all cells read 000000, write dropped.
//  5 request (239,80),(400,80),(240,400) -> 202020; col 12 write accepted, no cell changes.
//  6 back-to-back requests across x=255->256 (col0 code1, col1 code2) -> 00FFFF then FFFF00, no gaps.

Source files
------------

// File: rtl/vga_board_renderer.sv
// Game-board pixel source: maps timing-generator coordinates to RGB from a cell store.
// Optional GRID_LINE_EN draws grid gray on the first pixel row/column of empty cells.
module vga_board_renderer #(
  parameter int unsigned COLS      = 10,
  parameter int unsigned ROWS      = 20,
  parameter int unsigned CELL_LOG2 = 4,
  parameter int unsigned ORIGIN_X  = 240,
  parameter int unsigned ORIGIN_Y  = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pix_req,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_vblank,
  input  logic       i_clr,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [3:0] i_wr_col,
  input  logic [4:0] i_wr_row,
  input  logic [2:0] i_wr_code,
  output logic       o_pix_valid,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b
);

  localparam logic [10:0] OX       = 11'(ORIGIN_X);
  localparam logic [10:0] OY       = 11'(ORIGIN_Y);
  localparam logic [10:0] X_SPAN   = 11'(COLS << CELL_LOG2);
  localparam logic [10:0] Y_SPAN   = 11'(ROWS << CELL_LOG2);
  localparam logic [3:0]  COLS_L   = 4'(COLS);
  localparam logic [4:0]  ROWS_L   = 5'(ROWS);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  localparam logic StIdle  = 1'b0;
  localparam logic StClear = 1'b1;

  logic       state_q, state_d;
  logic [4:0] clr_row_q, clr_row_d;
  logic [2:0] cells_q [ROWS][COLS];
  logic       wr_fire;

  // Clear takes priority over a simultaneous write request.
  assign o_wr_ready = (state_q == StIdle) && i_vblank && !i_clr;
  assign wr_fire    = i_wr_valid && o_wr_ready;

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    case (state_q)
      StIdle: begin
        if (i_clr) begin
          state_d   = StClear;
          clr_row_d = '0;
        end
      end
      default: begin
        if (clr_row_q == LAST_ROW) begin
          state_d   = StIdle;
          clr_row_d = '0;
        end else begin
          clr_row_d = clr_row_q + 5'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      clr_row_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          cells_q[r][c] <= '0;
        end
      end
    end else if (state_q == StClear) begin
      for (int c = 0; c < COLS; c++) begin
        cells_q[clr_row_q][c] <= '0;
      end
    end else if (wr_fire && (i_wr_col < COLS_L) && (i_wr_row < ROWS_L)) begin
      cells_q[i_wr_row][i_wr_col] <= i_wr_code;
    end
  end

  // Stage 1: board-relative coordinates. An 11-bit difference never wraps into the span.
  logic [10:0] dx, dy;
  logic        in_board_d;
  logic [3:0]  col_d;
  logic [4:0]  row_d;

  always_comb begin
    dx         = {1'b0, i_x} - OX;
    dy         = {1'b0, i_y} - OY;
    in_board_d = ({1'b0, i_x} >= OX) && (dx < X_SPAN) && ({1'b0, i_y} >= OY) && (dy < Y_SPAN);
    col_d      = 4'(dx >> CELL_LOG2);
    row_d      = 5'(dy >> CELL_LOG2);
  end

  logic       s1_valid_q, s1_in_q;
  logic [3:0] s1_col_q;
  logic [4:0] s1_row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_in_q    <= 1'b0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
    end else begin
      s1_valid_q <= i_pix_req;
      s1_in_q    <= i_pix_req && in_board_d;
      s1_col_q   <= col_d;
      s1_row_q   <= row_d;
    end
  end

`ifdef GRID_LINE_EN
  logic s1_edge_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_edge_q <= 1'b0;
    end else begin
      s1_edge_q <= (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);
    end
  end
`endif

  function automatic logic [23:0] palette(input logic [2:0] code);
    case (code)
      3'd0:    palette = 24'h000000;
      3'd1:    palette = 24'h00FFFF;
      3'd2:    palette = 24'hFFFF00;
      3'd3:    palette = 24'h800080;
      3'd4:    palette = 24'h00FF00;
      3'd5:    palette = 24'hFF0000;
      3'd6:    palette = 24'h0000FF;
      default: palette = 24'hFF8000;
    endcase
  endfunction

  // Stage 2: cell lookup and palette.
  logic [2:0]  cell_code;
  logic [23:0] pix_rgb;

  always_comb begin
    cell_code = '0;
    pix_rgb   = 24'h202020;
    if (s1_in_q) begin
      cell_code = cells_q[s1_row_q][s1_col_q];
      pix_rgb   = palette(cell_code);
`ifdef GRID_LINE_EN
      if ((cell_code == 3'd0) && s1_edge_q) pix_rgb = 24'h404040;
`endif
    end
  end

  logic        pix_valid_q;
  logic [23:0] rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      pix_valid_q <= s1_valid_q;
      rgb_q       <= s1_valid_q ? pix_rgb : 24'h000000;
    end
  end

  assign o_pix_valid = pix_valid_q;
  assign o_r         = rgb_q[23:16];
  assign o_g         = rgb_q[15:8];
  assign o_b         = rgb_q[7:0];

endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed and random checks of vga_board_renderer against a board/palette model.
module tb_vga_board_renderer;

  localparam int NCOLS = 10;
  localparam int NROWS = 20;
  localparam int OXP   = 240;
  localparam int OYP   = 80;
  localparam int CELL  = 16;

  logic       clk, rst_n;
  logic       i_pix_req, i_vblank, i_clr, i_wr_valid;
  logic [9:0] i_x, i_y;
  logic [3:0] i_wr_col;
  logic [4:0] i_wr_row;
  logic [2:0] i_wr_code;
  logic       o_wr_ready, o_pix_valid;
  logic [7:0] o_r, o_g, o_b;

  vga_board_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_pix_req  (i_pix_req),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_vblank   (i_vblank),
    .i_clr      (i_clr),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .i_wr_col   (i_wr_col),
    .i_wr_row   (i_wr_row),
    .i_wr_code  (i_wr_code),
    .o_pix_valid(o_pix_valid),
    .o_r        (o_r),
    .o_g        (o_g),
    .o_b        (o_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          board [NROWS][NCOLS];
  int          clear_left;
  logic        pipe_v;
  logic [23:0] pipe_rgb;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pal(input int code);
    case (code)
      0: return 24'h000000;
      1: return 24'h00FFFF;
      2: return 24'hFFFF00;
      3: return 24'h800080;
      4: return 24'h00FF00;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'hFF8000;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(input int x, input int y);
    int code;
    if (x < OXP || x >= OXP + NCOLS * CELL || y < OYP || y >= OYP + NROWS * CELL)
      return 24'h202020;
    code = board[(y - OYP) / CELL][(x - OXP) / CELL];
`ifdef GRID_LINE_EN
    if (code == 0 && (((x - OXP) % CELL) == 0 || ((y - OYP) % CELL) == 0)) return 24'h404040;
`endif
    return pal(code);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOLS; c++) board[r][c] = 0;
    clear_left = 0;
    pipe_v     = 1'b0;
    pipe_rgb   = 24'h0;
  endtask

  // One clock: drive at the falling edge, check ready before the rising edge, check pixel after.
  task automatic cycle(input bit req, input int x, input int y, input bit vb, input bit clr,
                       input bit wv, input int col, input int row, input int code);
    logic exp_ready;
    logic [23:0] nrgb;
    i_pix_req  = req;
    i_x        = 10'(x);
    i_y        = 10'(y);
    i_vblank   = vb;
    i_clr      = clr;
    i_wr_valid = wv;
    i_wr_col   = 4'(col);
    i_wr_row   = 5'(row);
    i_wr_code  = 3'(code);
    #1;
    exp_ready = (clear_left == 0) && vb && !clr;
    check("wr_ready", {23'h0, o_wr_ready}, {23'h0, exp_ready});
    @(posedge clk);
    @(negedge clk);
    check("pix_valid", {23'h0, o_pix_valid}, {23'h0, pipe_v});
    check("rgb", {o_r, o_g, o_b}, pipe_rgb);
    if (exp_ready && wv && col < NCOLS && row < NROWS) board[row][col] = code;
    nrgb     = req ? model_pix(x, y) : 24'h0;
    pipe_v   = req;
    pipe_rgb = nrgb;
    if (clear_left > 0) clear_left--;
    else if (clr) begin
      clear_left = NROWS;
      for (int r = 0; r < NROWS; r++)
        for (int c = 0; c < NCOLS; c++) board[r][c] = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int col, input int row, input int code);
    cycle(0, 0, 0, 1, 0, 1, col, row, code);
  endtask

  task automatic rd(input int x, input int y);
    cycle(1, x, y, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    i_pix_req  = 0;
    i_vblank   = 0;
    i_clr      = 0;
    i_wr_valid = 0;
    rst_n      = 1'b0;
    #1;
    check("rst_pix_valid", {23'h0, o_pix_valid}, 24'h0);
    check("rst_rgb", {o_r, o_g, o_b}, 24'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    i_x = '0; i_y = '0; i_wr_col = '0; i_wr_row = '0; i_wr_code = '0;
    @(negedge clk);
    do_reset();

    // Empty board after reset, then a write during blanking.
    rd(250, 90);
    rd(240, 80);
    idle(1);
    wr(0, 0, 5);
    rd(241, 81);
    idle(1);

    // Write outside blanking waits; raising vblank accepts it.
    cycle(0, 0, 0, 0, 0, 1, 1, 0, 3);
    cycle(1, 257, 81, 0, 0, 1, 1, 0, 3);
    cycle(0, 0, 0, 1, 0, 1, 1, 0, 3);
    rd(257, 81);
    idle(1);

    // Fill, then clear together with a write request.
    for (int i = 0; i < 30; i++)
      wr($urandom_range(0, NCOLS - 1), $urandom_range(0, NROWS - 1), $urandom_range(1, 7));
    for (int i = 0; i < 10; i++) rd($urandom_range(OXP, OXP + 159), $urandom_range(OYP, OYP + 319));
    idle(1);
    cycle(0, 0, 0, 1, 1, 1, 2, 3, 6);
    for (int i = 0; i < NROWS; i++) cycle(0, 0, 0, 1, (i == 4), 1, 2, 3, 6);
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOLS; c++)
        rd(OXP + c * CELL + $urandom_range(0, 15), OYP + r * CELL + $urandom_range(0, 15));
    idle(1);

    // Out-of-board pixels and out-of-range writes.
    wr(12, 0, 7);
    wr(0, 25, 7);
    wr(9, 19, 4);
    rd(239, 80);
    rd(400, 80);
    rd(240, 400);
    rd(399, 399);
    rd(400, 399);
    rd(1023, 1023);
    for (int c = 0; c < NCOLS; c++) rd(OXP + c * CELL + 5, OYP + 5);
    idle(1);

    // Back-to-back across a cell boundary.
    wr(0, 0, 1);
    wr(1, 0, 2);
    rd(255, 80);
    rd(256, 80);
    rd(255, 95);
    rd(256, 96);
    idle(1);

    // Random traffic (no clears).
    for (int i = 0; i < 500; i++) begin
      bit req, vb, wv;
      req = ($urandom_range(0, 9) < 8);
      vb  = ($urandom_range(0, 2) == 0);
      wv  = $urandom_range(0, 1) == 1;
      cycle(req, $urandom_range(200, 440), $urandom_range(60, 420), vb, 0, wv,
            $urandom_range(0, 11), $urandom_range(0, 21), $urandom_range(0, 7));
    end
    idle(1);

    // Reset in the middle of a clear and with pixels in flight.
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(5);
    rd(300, 100);
    rd(301, 101);
    do_reset();
    cycle(0, 0, 0, 1, 0, 1, 3, 3, 6);
    rd(OXP + 3 * CELL + 4, OYP + 3 * CELL + 4);
    rd(OXP + 7 * CELL + 4, OYP + 10 * CELL + 4);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
